// File: rtl/interrupt_controller.sv
// Interrupt request producer: synchronizes and edge-detects irq_in, keeps masked pending bits,
// and runs a single-level request/service handshake with the core. Optional macro IRQ_SYNC2_EN.
module interrupt_controller #(
  parameter int                   NUM_SRC    = 4,
  parameter int                   ID_W       = 2,
  parameter logic [NUM_SRC-1:0]   MASK_RESET = {NUM_SRC{1'b1}}
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_in,
  input  logic               int_ack,
  input  logic               int_return,
  input  logic               mask_wr,
  input  logic [NUM_SRC-1:0] mask_data,
  input  logic [NUM_SRC-1:0] pend_clr,
  output logic               int_req,
  output logic [ID_W-1:0]    int_id,
  output logic               in_service,
  output logic [NUM_SRC-1:0] pending
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQUEST = 2'd1,
    S_SERVICE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_int_req;
  logic [ID_W-1:0]    r_int_id;
  logic               r_in_service;
  logic [NUM_SRC-1:0] r_pending;
  logic [NUM_SRC-1:0] r_mask;
  logic [NUM_SRC-1:0] r_hist;
  logic [NUM_SRC-1:0] r_rise;
  logic [NUM_SRC-1:0] w_sync_out;
  logic [NUM_SRC-1:0] w_eligible;
  logic [NUM_SRC-1:0] w_ack_clr;
  logic [ID_W-1:0]    w_winner;
  logic               w_any;
  logic               w_req_nxt;
  logic [ID_W-1:0]    w_id_nxt;
  logic               w_svc_nxt;
  logic               w_ack_hit;

`ifdef IRQ_SYNC2_EN
  logic [NUM_SRC-1:0] r_sync1;
  logic [NUM_SRC-1:0] r_sync2;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= irq_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_sync_out = r_sync2;
`else
  logic [NUM_SRC-1:0] r_sync1;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
    end else begin
      r_sync1 <= irq_in;
    end
  end

  assign w_sync_out = r_sync1;
`endif

  // The rise is registered before it reaches pending, so a new edge costs one extra cycle.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_hist <= '0;
      r_rise <= '0;
    end else begin
      r_hist <= w_sync_out;
      r_rise <= w_sync_out & ~r_hist;
    end
  end

  assign w_eligible = r_pending & r_mask;
  assign w_any      = |w_eligible;

  // Scan from the top so the lowest eligible index is the last one written.
  always_comb begin
    w_winner = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (w_eligible[i]) begin
        w_winner = ID_W'(i);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_req_nxt   = r_int_req;
    w_id_nxt    = r_int_id;
    w_svc_nxt   = r_in_service;
    w_ack_hit   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_req_nxt = 1'b0;
        if (w_any) begin
          w_state_nxt = S_REQUEST;
          w_req_nxt   = 1'b1;
          w_id_nxt    = w_winner;
        end
      end
      S_REQUEST: begin
        if (int_ack) begin
          w_ack_hit   = 1'b1;
          w_svc_nxt   = 1'b1;
          w_req_nxt   = 1'b0;
          w_state_nxt = S_SERVICE;
        end else if (!w_any) begin
          w_req_nxt   = 1'b0;
          w_state_nxt = S_IDLE;
        end else begin
          w_id_nxt = w_winner;
        end
      end
      S_SERVICE: begin
        if (int_return) begin
          w_svc_nxt   = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_req_nxt   = 1'b0;
        w_svc_nxt   = 1'b0;
      end
    endcase
  end

  always_comb begin
    w_ack_clr = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_ack_clr[i] = w_ack_hit && (r_int_id == ID_W'(i));
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_int_req    <= 1'b0;
      r_int_id     <= '0;
      r_in_service <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_int_req    <= w_req_nxt;
      r_int_id     <= w_id_nxt;
      r_in_service <= w_svc_nxt;
    end
  end

  // A fresh rise overrides both software clear and acknowledge clear in the same cycle.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_pending <= '0;
      r_mask    <= MASK_RESET;
    end else begin
      r_pending <= r_rise | (r_pending & ~pend_clr & ~w_ack_clr);
      if (mask_wr) begin
        r_mask <= mask_data;
      end
    end
  end

  assign int_req    = r_int_req;
  assign int_id     = r_int_id;
  assign in_service = r_in_service;
  assign pending    = r_pending;

endmodule

// File: tb/tb_interrupt_controller.sv
// Bench for interrupt_controller: directed scenarios plus random traffic checked against a
// cycle-level reference built from a sample delay line and the request/service rules.
module tb_interrupt_controller;

`ifdef IRQ_SYNC2_EN
  localparam int L = 3;
`else
  localparam int L = 2;
`endif

  logic       CLOCK_50 = 1'b0;
  logic       reset;
  logic [3:0] irq_in;
  logic       int_ack;
  logic       int_return;
  logic       mask_wr;
  logic [3:0] mask_data;
  logic [3:0] pend_clr;
  logic       int_req;
  logic [1:0] int_id;
  logic       in_service;
  logic [3:0] pending;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [3:0] m_pend;
  logic [3:0] m_mask;
  logic       m_req;
  logic [1:0] m_id;
  logic       m_svc;
  int         m_phase;   // 0 idle, 1 requesting, 2 in handler
  logic [3:0] m_h [0:3]; // m_h[j] = irq_in sampled j+1 edges ago

  interrupt_controller dut (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .irq_in    (irq_in),
    .int_ack   (int_ack),
    .int_return(int_return),
    .mask_wr   (mask_wr),
    .mask_data (mask_data),
    .pend_clr  (pend_clr),
    .int_req   (int_req),
    .int_id    (int_id),
    .in_service(in_service),
    .pending   (pending)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  function void model_reset();
    m_pend  = '0;
    m_mask  = 4'hF;
    m_req   = 1'b0;
    m_id    = '0;
    m_svc   = 1'b0;
    m_phase = 0;
    for (int j = 0; j < 4; j++) m_h[j] = '0;
  endfunction

  function void model_step();
    logic [3:0] rise;
    logic [3:0] elig;
    logic [3:0] ackc;
    logic [1:0] win;
    if (reset) begin
      model_reset();
      return;
    end
    rise = m_h[L-1] & ~m_h[L];
    elig = m_pend & m_mask;
    ackc = '0;
    win  = '0;
    for (int i = 3; i >= 0; i--) if (elig[i]) win = 2'(i);
    if (m_phase == 0) begin
      if (elig != 0) begin
        m_req = 1'b1; m_id = win; m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (int_ack) begin
        ackc[m_id] = 1'b1; m_svc = 1'b1; m_req = 1'b0; m_phase = 2;
      end else if (elig == 0) begin
        m_req = 1'b0; m_phase = 0;
      end else begin
        m_id = win;
      end
    end else begin
      if (int_return) begin
        m_svc = 1'b0; m_phase = 0;
      end
    end
    m_pend = rise | (m_pend & ~pend_clr & ~ackc);
    if (mask_wr) m_mask = mask_data;
    for (int j = 3; j > 0; j--) m_h[j] = m_h[j-1];
    m_h[0] = irq_in;
  endfunction

  task automatic cycle();
    @(posedge CLOCK_50);
    model_step();
    @(negedge CLOCK_50);
  endtask

  task automatic do_reset();
    reset = 1'b1; irq_in = '0; int_ack = 1'b0; int_return = 1'b0;
    mask_wr = 1'b0; mask_data = '0; pend_clr = '0;
    model_reset();
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({int_req, int_id, in_service, pending} !== 8'h00) begin
      bad++; $display("FAIL reset_state: got %h exp 00", {int_req, int_id, in_service, pending});
    end
    irq_in = 4'hF;
    for (int c = 0; c < 12; c++) begin
      cycle();
      if (int_req) break;
    end
    total++;
    if ({int_req, int_id, pending} !== {1'b1, 2'd0, 4'hF}) begin
      bad++; $display("FAIL reset_mask_all: got %h exp %h", {int_req, int_id, pending}, {1'b1, 2'd0, 4'hF});
    end
    int_ack = 1'b1; cycle(); int_ack = 1'b0;
    total++;
    if ({int_req, in_service, pending} !== {1'b0, 1'b1, 4'hE}) begin
      bad++; $display("FAIL reset_pre_svc: got %h exp %h", {int_req, in_service, pending}, {1'b0, 1'b1, 4'hE});
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if ({int_req, int_id, in_service, pending} !== 8'h00) begin
      bad++; $display("FAIL reset_async_mid_svc: got %h exp 00", {int_req, int_id, in_service, pending});
    end
    do_reset();
  endtask

  task automatic test_single();
    int lat_p = 0;
    int lat_r = 0;
    do_reset();
    irq_in = 4'b0100;
    for (int c = 1; c <= 12; c++) begin
      cycle();
      total++;
      if ({int_req, int_id, in_service, pending} !== {m_req, m_id, m_svc, m_pend}) begin
        bad++; $display("FAIL single_model c=%0d: got %h exp %h", c, {int_req, int_id, in_service, pending}, {m_req, m_id, m_svc, m_pend});
      end
      if (lat_p == 0 && pending != 0) lat_p = c;
      if (int_req) begin
        lat_r = c;
        break;
      end
    end
    total++;
    if ({lat_p, lat_r} !== {L + 1, L + 2}) begin
      bad++; $display("FAIL single_latency: got pend=%0d req=%0d exp pend=%0d req=%0d", lat_p, lat_r, L + 1, L + 2);
    end
    total++;
    if ({int_id, pending} !== {2'd2, 4'b0100}) begin
      bad++; $display("FAIL single_id: got %h exp %h", {int_id, pending}, {2'd2, 4'b0100});
    end
    int_ack = 1'b1; cycle(); int_ack = 1'b0;
    total++;
    if ({int_req, in_service, pending} !== {1'b0, 1'b1, 4'b0000}) begin
      bad++; $display("FAIL single_ack: got %h exp %h", {int_req, in_service, pending}, {1'b0, 1'b1, 4'b0000});
    end
    int_return = 1'b1; cycle(); int_return = 1'b0;
    total++;
    if ({int_req, in_service} !== 2'b00) begin
      bad++; $display("FAIL single_return: got %b exp 00", {int_req, in_service});
    end
  endtask

  task automatic test_priority();
    do_reset();
    irq_in = 4'b1010;
    for (int c = 0; c < 12; c++) begin
      cycle();
      if (int_req) break;
    end
    total++;
    if ({int_req, int_id} !== {1'b1, 2'd1}) begin
      bad++; $display("FAIL prio_first: got %h exp %h", {int_req, int_id}, {1'b1, 2'd1});
    end
    int_ack = 1'b1; cycle(); int_ack = 1'b0;
    cycle();
    int_return = 1'b1; cycle(); int_return = 1'b0;
    total++;
    if (int_req !== 1'b0) begin
      bad++; $display("FAIL prio_no_early_req: got %b exp 0", int_req);
    end
    for (int c = 0; c < 6; c++) begin
      cycle();
      if (int_req) break;
    end
    total++;
    if ({int_req, int_id, pending} !== {1'b1, 2'd3, 4'b1000}) begin
      bad++; $display("FAIL prio_second: got %h exp %h", {int_req, int_id, pending}, {1'b1, 2'd3, 4'b1000});
    end
  endtask

  task automatic test_mask_withdraw();
    do_reset();
    irq_in = 4'b0001;
    for (int c = 0; c < 12; c++) begin
      cycle();
      if (int_req) break;
    end
    total++;
    if ({int_req, int_id} !== {1'b1, 2'd0}) begin
      bad++; $display("FAIL mask_req0: got %h exp %h", {int_req, int_id}, {1'b1, 2'd0});
    end
    mask_wr = 1'b1; mask_data = 4'b1110; cycle(); mask_wr = 1'b0;
    total++;
    if (int_req !== 1'b1) begin
      bad++; $display("FAIL mask_one_cycle_late: got %b exp 1", int_req);
    end
    cycle();
    total++;
    if ({int_req, in_service, pending} !== {1'b0, 1'b0, 4'b0001}) begin
      bad++; $display("FAIL mask_withdraw: got %h exp %h", {int_req, in_service, pending}, {1'b0, 1'b0, 4'b0001});
    end
    for (int c = 0; c < 4; c++) begin
      cycle();
      total++;
      if ({int_req, int_id, in_service, pending} !== {m_req, m_id, m_svc, m_pend}) begin
        bad++; $display("FAIL mask_idle_model: got %h exp %h", {int_req, int_id, in_service, pending}, {m_req, m_id, m_svc, m_pend});
      end
    end
  endtask

  task automatic test_service_block();
    do_reset();
    irq_in = 4'b0100;
    for (int c = 0; c < 12; c++) begin
      cycle();
      if (int_req) break;
    end
    int_ack = 1'b1; cycle(); int_ack = 1'b0;
    irq_in = 4'b0101;
    for (int c = 0; c < 8; c++) begin
      cycle();
      total++;
      if (int_req !== 1'b0) begin
        bad++; $display("FAIL svc_no_req c=%0d: got %b exp 0", c, int_req);
      end
    end
    total++;
    if ({in_service, pending} !== {1'b1, 4'b0001}) begin
      bad++; $display("FAIL svc_accum: got %h exp %h", {in_service, pending}, {1'b1, 4'b0001});
    end
    int_ack = 1'b1; int_return = 1'b1; cycle(); int_ack = 1'b0; int_return = 1'b0;
    total++;
    if ({int_req, in_service, pending} !== {1'b0, 1'b0, 4'b0001}) begin
      bad++; $display("FAIL svc_return: got %h exp %h", {int_req, in_service, pending}, {1'b0, 1'b0, 4'b0001});
    end
    cycle();
    total++;
    if ({int_req, int_id} !== {1'b1, 2'd0}) begin
      bad++; $display("FAIL svc_rereq: got %h exp %h", {int_req, int_id}, {1'b1, 2'd0});
    end
  endtask

  task automatic test_set_wins();
    int sets = 0;
    do_reset();
    irq_in = 4'b0100;
    cycle();
    for (int c = 0; c < L - 1; c++) cycle();
    pend_clr = 4'b0100; cycle(); pend_clr = '0;
    total++;
    if (pending !== 4'b0100) begin
      bad++; $display("FAIL set_wins: got %b exp 0100", pending);
    end
    pend_clr = 4'b0100; cycle(); pend_clr = '0;
    total++;
    if (pending !== 4'b0000) begin
      bad++; $display("FAIL clr_works: got %b exp 0000", pending);
    end
    for (int c = 0; c < 20; c++) begin
      cycle();
      if (pending[2]) sets++;
      total++;
      if ({int_req, int_id, in_service, pending} !== {m_req, m_id, m_svc, m_pend}) begin
        bad++; $display("FAIL held_model c=%0d: got %h exp %h", c, {int_req, int_id, in_service, pending}, {m_req, m_id, m_svc, m_pend});
      end
    end
    total++;
    if (sets !== 0) begin
      bad++; $display("FAIL held_single_rise: got %0d extra sets exp 0", sets);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 3) == 0) irq_in[$urandom_range(0, 3)] = ~irq_in[$urandom_range(0, 3)];
      if ($urandom_range(0, 3) == 0) irq_in = irq_in ^ 4'(1 << $urandom_range(0, 3));
      int_ack    = ($urandom_range(0, 3) == 0);
      int_return = ($urandom_range(0, 5) == 0);
      mask_wr    = ($urandom_range(0, 15) == 0);
      mask_data  = 4'($urandom_range(0, 15));
      pend_clr   = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      cycle();
      total++;
      if ({int_req, int_id, in_service, pending} !== {m_req, m_id, m_svc, m_pend}) begin
        bad++; $display("FAIL random c=%0d: got %h exp %h", c, {int_req, int_id, in_service, pending}, {m_req, m_id, m_svc, m_pend});
      end
    end
    int_ack = 1'b0; int_return = 1'b0; mask_wr = 1'b0; pend_clr = '0;
  endtask

  initial begin
    #1_000_000;
    bad++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_mask_withdraw();
    test_service_block();
    test_set_wins();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
